// File: rtl/cacheline_adaptor.sv
// Bridges one 256-bit cache-line transfer to a four-beat 64-bit memory burst, and back for reads.
// Define ADAPTOR_WRITE_CAPTURE_EN to latch the write line at acceptance; otherwise line_i must stay stable.
module cacheline_adaptor (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         read_i,
  input  logic         write_i,
  input  logic [31:0]  address_i,
  input  logic [255:0] line_i,
  output logic [255:0] line_o,
  output logic         resp_o,
  input  logic [63:0]  burst_i,
  output logic [63:0]  burst_o,
  output logic [31:0]  address_o,
  output logic         read_o,
  output logic         write_o,
  input  logic         resp_i
);

  // state | meaning
  // IDLE  | waiting for a line request; write has priority
  // READ  | collecting four beats from memory into line_o
  // WRITE | presenting four beats of the line to memory
  // DONE  | one-cycle completion pulse, requests ignored
  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t       r_state;
  state_t       w_next;
  logic [1:0]   r_beat;
  logic [255:0] r_line_o;
  logic [31:0]  r_address_o;
  logic         r_read_o;
  logic         r_write_o;
  logic         r_resp_o;
  logic [255:0] w_src;
  logic [7:0]   w_lsb;
  logic         w_unused_addr;

  assign w_lsb         = {r_beat, 6'd0};
  assign w_unused_addr = ^address_i[4:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (write_i)     w_next = WRITE;
        else if (read_i) w_next = READ;
      end
      READ:    if (resp_i && (r_beat == 2'd3)) w_next = DONE;
      WRITE:   if (resp_i && (r_beat == 2'd3)) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_beat      <= 2'd0;
      r_line_o    <= '0;
      r_address_o <= '0;
      r_read_o    <= 1'b0;
      r_write_o   <= 1'b0;
      r_resp_o    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_read_o  <= (w_next == READ);
      r_write_o <= (w_next == WRITE);
      r_resp_o  <= (w_next == DONE);
      case (r_state)
        IDLE: begin
          r_beat      <= 2'd0;
          r_address_o <= {address_i[31:5], 5'b0};
        end
        READ: begin
          if (resp_i) begin
            r_line_o[w_lsb +: 64] <= burst_i;
            // beat saturates at 3; the clear back to 0 happens only in IDLE
            if (r_beat != 2'd3) r_beat <= r_beat + 2'd1;
          end
        end
        WRITE: begin
          if (resp_i && (r_beat != 2'd3)) r_beat <= r_beat + 2'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef ADAPTOR_WRITE_CAPTURE_EN
  logic [255:0] r_wbuf;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                         r_wbuf <= '0;
    else if ((r_state == IDLE) && write_i) r_wbuf <= line_i;
  end

  assign w_src = r_wbuf;
`else
  assign w_src = line_i;
`endif

  assign burst_o   = (r_state == WRITE) ? w_src[w_lsb +: 64] : 64'd0;
  assign line_o    = r_line_o;
  assign address_o = r_address_o;
  assign read_o    = r_read_o;
  assign write_o   = r_write_o;
  assign resp_o    = r_resp_o;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed bench for cacheline_adaptor: read, stalled write, priority, mid-burst reset,
// write-line capture behaviour and back-to-back reads.
module tb_cacheline_adaptor;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         read_i;
  logic         write_i;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic [31:0]  address_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  int checks = 0;
  int errors = 0;

  localparam logic [63:0] B1 = {16{4'h1}};
  localparam logic [63:0] B2 = {16{4'h2}};
  localparam logic [63:0] B3 = {16{4'h3}};
  localparam logic [63:0] B4 = {16{4'h4}};
  localparam logic [63:0] B5 = {16{4'h5}};
  localparam logic [63:0] B6 = {16{4'h6}};
  localparam logic [63:0] B7 = {16{4'h7}};
  localparam logic [63:0] B8 = {16{4'h8}};
  localparam logic [63:0] B9 = {16{4'h9}};
  localparam logic [63:0] BA = {16{4'hA}};
  localparam logic [63:0] BB = {16{4'hB}};
  localparam logic [63:0] BC = {16{4'hC}};
  localparam logic [63:0] BD = {16{4'hD}};
  localparam logic [63:0] BE = {16{4'hE}};
  localparam logic [63:0] BF = {16{4'hF}};
  localparam logic [63:0] B0 = 64'h0123_4567_89AB_CDEF;

  logic [255:0] line1;
  logic [255:0] wline;
  logic [255:0] cline;
  logic [63:0]  beats [4];
  logic [63:0]  cexp;

  cacheline_adaptor dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .read_i    (read_i),
    .write_i   (write_i),
    .address_i (address_i),
    .line_i    (line_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    address_i = 32'h0;
    line_i    = '0;
    burst_i   = 64'h0;
    resp_i    = 1'b0;
    step();
    step();
    chk("rst_read_o",    read_o,    1'b0);
    chk("rst_write_o",   write_o,   1'b0);
    chk("rst_resp_o",    resp_o,    1'b0);
    chk("rst_address_o", address_o, 32'h0);
    chk("rst_line_o",    line_o,    256'h0);
    chk("rst_burst_o",   burst_o,   64'h0);
    reset_n = 1'b1;
    step();

    // Read with zero stalls; resp_i in IDLE must be ignored
    resp_i    = 1'b1;
    burst_i   = BF;
    read_i    = 1'b1;
    address_i = 32'h0000_1234;
    beats[0] = B1; beats[1] = B2; beats[2] = B3; beats[3] = B4;
    line1 = {B4, B3, B2, B1};
    step();
    chk("rd_address_o", address_o, 32'h0000_1220);
    for (int i = 0; i < 4; i++) begin
      burst_i = beats[i];
      resp_i  = 1'b1;
      chk($sformatf("rd_read_o_b%0d", i), read_o, 1'b1);
      chk($sformatf("rd_resp_o_b%0d", i), resp_o, 1'b0);
      step();
    end
    resp_i = 1'b0;
    chk("rd_resp_o",   resp_o,  1'b1);
    chk("rd_read_done", read_o, 1'b0);
    chk("rd_line_o",   line_o,  line1);
    step();
    read_i = 1'b0;
    chk("rd_resp_pulse", resp_o, 1'b0);
    step();
    chk("rd_idle_read_o", read_o, 1'b0);
    chk("rd_line_hold",   line_o, line1);

    // Write with one stall on beat 1
    wline     = {BD, BC, BB, BA};
    line_i    = wline;
    write_i   = 1'b1;
    address_i = 32'h0000_801F;
    step();
    chk("wr_address_o", address_o, 32'h0000_8000);
    chk("wr_write_o",   write_o,   1'b1);
    chk("wr_burst_0",   burst_o,   BA);
    resp_i = 1'b1;
    step();
    chk("wr_burst_1", burst_o, BB);
    resp_i = 1'b0;
    step();
    chk("wr_burst_1_held", burst_o, BB);
    chk("wr_stall_write_o", write_o, 1'b1);
    resp_i = 1'b1;
    step();
    chk("wr_burst_2", burst_o, BC);
    step();
    chk("wr_burst_3", burst_o, BD);
    chk("wr_resp_early", resp_o, 1'b0);
    step();
    resp_i = 1'b0;
    chk("wr_resp_o",     resp_o,  1'b1);
    chk("wr_write_done", write_o, 1'b0);
    chk("wr_read_never", read_o,  1'b0);
    chk("wr_line_o_kept", line_o, line1);
    step();
    write_i = 1'b0;
    chk("wr_burst_idle", burst_o, 64'h0);

    // Simultaneous read/write: write wins
    read_i  = 1'b1;
    write_i = 1'b1;
    line_i  = {BE, B9, B6, B3};
    step();
    chk("both_write_o", write_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      resp_i  = 1'b1;
      burst_i = B8;
      chk($sformatf("both_read_o_b%0d", i), read_o, 1'b0);
      step();
    end
    resp_i = 1'b0;
    chk("both_resp_o",  resp_o, 1'b1);
    chk("both_line_o",  line_o, line1);
    step();
    read_i  = 1'b0;
    write_i = 1'b0;
    step();

    // Reset after beat 2 of a read, then a clean read
    read_i    = 1'b1;
    address_i = 32'h0000_4010;
    step();
    for (int i = 0; i < 3; i++) begin
      resp_i  = 1'b1;
      burst_i = (i == 0) ? B5 : (i == 1) ? B6 : B7;
      step();
    end
    read_i  = 1'b0;
    resp_i  = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_read_o",    read_o,    1'b0);
    chk("mid_rst_write_o",   write_o,   1'b0);
    chk("mid_rst_resp_o",    resp_o,    1'b0);
    chk("mid_rst_address_o", address_o, 32'h0);
    chk("mid_rst_line_o",    line_o,    256'h0);
    chk("mid_rst_burst_o",   burst_o,   64'h0);
    #2;
    reset_n = 1'b1;
    step();
    read_i    = 1'b1;
    address_i = 32'h0000_4010;
    beats[0] = B7; beats[1] = B8; beats[2] = B9; beats[3] = BA;
    step();
    chk("post_rst_address_o", address_o, 32'h0000_4000);
    for (int i = 0; i < 4; i++) begin
      resp_i  = 1'b1;
      burst_i = beats[i];
      step();
    end
    resp_i = 1'b0;
    chk("post_rst_resp_o", resp_o, 1'b1);
    chk("post_rst_line_o", line_o, {BA, B9, B8, B7});
    step();
    read_i = 1'b0;
    step();

    // Line changed to 0 one cycle after write acceptance
    cline   = {B4, B3, B2, B0};
    line_i  = cline;
    write_i = 1'b1;
    step();
    line_i = '0;
    #1;
    for (int i = 0; i < 4; i++) begin
`ifdef ADAPTOR_WRITE_CAPTURE_EN
      cexp = (i == 0) ? B0 : (i == 1) ? B2 : (i == 2) ? B3 : B4;
`else
      cexp = 64'h0;
`endif
      chk($sformatf("cap_burst_%0d", i), burst_o, cexp);
      resp_i = 1'b1;
      step();
    end
    resp_i = 1'b0;
    chk("cap_resp_o", resp_o, 1'b1);
    step();
    write_i = 1'b0;
    step();

    // Back-to-back reads: second resp_o six cycles after the first
    read_i    = 1'b1;
    address_i = 32'h0000_0040;
    step();
    for (int i = 0; i < 4; i++) begin
      resp_i  = 1'b1;
      burst_i = (i == 0) ? BB : (i == 1) ? BC : (i == 2) ? BD : BE;
      step();
    end
    read_i  = 1'b0;
    resp_i  = 1'b1;
    burst_i = BF;
    chk("b2b_resp_1", resp_o, 1'b1);
    chk("b2b_line_1", line_o, {BE, BD, BC, BB});
    step();
    resp_i    = 1'b0;
    read_i    = 1'b1;
    address_i = 32'h0000_0080;
    chk("b2b_line_1_hold", line_o, {BE, BD, BC, BB});
    chk("b2b_gap_0", resp_o, 1'b0);
    step();
    chk("b2b_read_o", read_o, 1'b1);
    chk("b2b_address_o", address_o, 32'h0000_0080);
    for (int i = 0; i < 4; i++) begin
      resp_i  = 1'b1;
      burst_i = (i == 0) ? B1 : (i == 1) ? B3 : (i == 2) ? B5 : B7;
      chk($sformatf("b2b_gap_%0d", i + 1), resp_o, 1'b0);
      step();
    end
    resp_i = 1'b0;
    chk("b2b_resp_2", resp_o, 1'b1);
    chk("b2b_line_2", line_o, {B7, B5, B3, B1});
    step();
    read_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
